// File: rtl/mseq_pkg.sv
// rtl/mseq_pkg.sv - shared m-sequence link constants, FSM state type and rate helper
package mseq_pkg;

    localparam int                        DEF_LFSR_LEN  = 7;
    localparam logic [DEF_LFSR_LEN-1:0]   DEF_LFSR_TAPS = 7'b1100000;
    localparam logic [DEF_LFSR_LEN-1:0]   DEF_SEED      = 7'h7F;
    localparam int                        DEF_INC_W     = 32;

    // Increment per Hz of bit rate for a 2 MHz clock and a 32-bit accumulator (2^32 / 2e6).
    localparam int unsigned               HZ_TO_INC     = 2147;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } mseq_state_t;

    function automatic logic [DEF_INC_W-1:0] rate_to_inc(input int unsigned f_bit_hz);
        logic [63:0] prod;
        prod = 64'(f_bit_hz) * 64'(HZ_TO_INC);
        return prod[DEF_INC_W-1:0];
    endfunction

endpackage

// File: rtl/mseq_lfsr.sv
// rtl/mseq_lfsr.sv - Fibonacci LFSR with seed load, shift and lock-up recovery
module mseq_lfsr
    import mseq_pkg::*;
#(
    parameter int             LEN  = DEF_LFSR_LEN,
    parameter logic [LEN-1:0] TAPS = LEN'(DEF_LFSR_TAPS),
    parameter logic [LEN-1:0] SEED = LEN'(DEF_SEED)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic shift,
    output logic out_bit,
    output logic at_seed
);

    logic [LEN-1:0] lfsr;
    logic           fb;

    assign fb      = ^(lfsr & TAPS);
    assign out_bit = lfsr[LEN-1];
    assign at_seed = (lfsr == SEED);

    // An all-zero register would never leave zero, so it is treated like a load.
    always_ff @(posedge clk) begin
        if (rst || load || (lfsr == '0)) begin
            lfsr <= SEED;
        end else if (shift) begin
            lfsr <= {lfsr[LEN-2:0], fb};
        end
    end

endmodule

// File: rtl/mseq_nco_transmitter.sv
// rtl/mseq_nco_transmitter.sv - NCO-timed m-sequence transmitter; MSEQ_ERR_INJECT_EN adds single-bit error injection
module mseq_nco_transmitter
    import mseq_pkg::*;
#(
    parameter int                  LFSR_LEN  = DEF_LFSR_LEN,
    parameter logic [LFSR_LEN-1:0] LFSR_TAPS = LFSR_LEN'(DEF_LFSR_TAPS),
    parameter logic [LFSR_LEN-1:0] SEED      = LFSR_LEN'(DEF_SEED),
    parameter int                  INC_W     = DEF_INC_W
) (
    input  logic             clk_2m,
    input  logic             rst,
    input  logic             enable,
    input  logic [INC_W-1:0] rate_inc,
    input  logic             rate_load,
    input  logic             err_inject,
    output logic             m_seq_out,
    output logic             bit_clk,
    output logic             bit_strobe,
    output logic             frame_start,
    output logic             running
);

    mseq_state_t      state;
    mseq_state_t      state_next;
    logic [INC_W-1:0] phase;
    logic [INC_W-1:0] inc_act;
    logic [INC_W-1:0] inc_pend;
    logic [INC_W:0]   sum;
    logic             boundary;
    logic             emit;
    logic             out_bit;
    logic             at_seed;
    logic             flip;

    mseq_lfsr #(
        .LEN  (LFSR_LEN),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk_2m),
        .rst     (rst),
        .load    (state_next == IDLE),
        .shift   (emit),
        .out_bit (out_bit),
        .at_seed (at_seed)
    );

    // A new bit is emitted on the IDLE->RUN edge and on every RUN boundary; a STOP boundary ends the burst.
    always_comb begin
        sum        = {1'b0, phase} + {1'b0, inc_act};
        boundary   = (state != IDLE) && sum[INC_W];
        state_next = state;
        emit       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                    emit       = 1'b1;
                end
            end
            RUN: begin
                emit = boundary;
                if (!enable) state_next = STOP;
            end
            STOP: begin
                if (boundary)    state_next = IDLE;
                else if (enable) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MSEQ_ERR_INJECT_EN
    logic err_flag;

    always_ff @(posedge clk_2m) begin
        if (rst || state == IDLE || state_next == IDLE) begin
            err_flag <= 1'b0;
        end else if (emit) begin
            err_flag <= ~err_flag & err_inject;
        end else if (err_inject) begin
            err_flag <= 1'b1;
        end
    end

    assign flip = err_flag;
`else
    logic unused_err_inject;

    assign unused_err_inject = err_inject;
    assign flip              = 1'b0;
`endif

    always_ff @(posedge clk_2m) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            inc_act     <= '0;
            inc_pend    <= '0;
            m_seq_out   <= 1'b0;
            bit_clk     <= 1'b0;
            bit_strobe  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            state <= state_next;
            if (rate_load) inc_pend <= rate_inc;
            // Rate only changes between bits; a load landing on the boundary itself applies to the next bit.
            if (state == IDLE || boundary) inc_act <= rate_load ? rate_inc : inc_pend;
            phase       <= (state == IDLE || state_next == IDLE) ? '0 : sum[INC_W-1:0];
            bit_clk     <= (state_next == IDLE) ? 1'b0 : phase[INC_W-1];
            bit_strobe  <= emit;
            frame_start <= emit & at_seed;
            if (state_next == IDLE) begin
                m_seq_out <= 1'b0;
            end else if (emit) begin
                m_seq_out <= out_bit ^ flip;
            end
            running <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_mseq_nco_transmitter.sv
// tb/tb_mseq_nco_transmitter.sv - self-checking bench for mseq_nco_transmitter
module tb_mseq_nco_transmitter;

    typedef longint unsigned u64_t;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        ld;
        logic [31:0] inc;
        logic [3:0]  exp;   // {running, m_seq_out, bit_strobe, frame_start}
    } vec_t;

`ifdef MSEQ_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    localparam logic [31:0] INC_10K = 32'd21470000;
    localparam logic [31:0] INC_20K = 32'd42940000;
    localparam logic [31:0] HALF    = 32'h8000_0000;

    logic        clk_2m     = 1'b0;
    logic        rst        = 1'b1;
    logic        enable     = 1'b0;
    logic [31:0] rate_inc   = '0;
    logic        rate_load  = 1'b0;
    logic        err_inject = 1'b0;
    logic        m_seq_out;
    logic        bit_clk;
    logic        bit_strobe;
    logic        frame_start;
    logic        running;

    int   passed = 0;
    int   total  = 0;
    u64_t cyc    = 0;
    bit   gold[127];

    mseq_nco_transmitter dut (
        .clk_2m      (clk_2m),
        .rst         (rst),
        .enable      (enable),
        .rate_inc    (rate_inc),
        .rate_load   (rate_load),
        .err_inject  (err_inject),
        .m_seq_out   (m_seq_out),
        .bit_clk     (bit_clk),
        .bit_strobe  (bit_strobe),
        .frame_start (frame_start),
        .running     (running)
    );

    always #5 clk_2m = ~clk_2m;
    always @(posedge clk_2m) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk_2m);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Clock edge (counted from the edge that emits the first bit) on which bit n appears.
    function automatic u64_t kn(input int n, input logic [31:0] inc);
        return ((u64_t'(n) << 32) + u64_t'(inc) - 1) / u64_t'(inc);
    endfunction

    task automatic run_seq(input string name, input logic [31:0] inc, input int nbits, input int err_bit);
        u64_t        k_stop, k_drop, k_err;
        int          n, bad;
        logic        exp_bit, exp_clk;
        logic [63:0] prod;
        logic [4:0]  act_v;
        k_stop  = kn(nbits, inc);
        k_drop  = kn(nbits - 1, inc) + 3;
        k_err   = (err_bit >= 0) ? kn(err_bit, inc) : '1;
        n       = 0;
        bad     = 0;
        exp_bit = 1'b0;
        rate_inc = inc; rate_load = 1'b1; enable = 1'b0; step();
        rate_load = 1'b0; enable = 1'b1; step();
        for (u64_t c = 0; c <= k_stop; c++) begin
            prod    = (c - 1) * u64_t'(inc);
            exp_clk = (c == 0 || c == k_stop) ? 1'b0 : prod[31];
            act_v   = {running, m_seq_out, bit_strobe, frame_start, bit_clk};
            if (c == k_stop) begin
                check({name, " back to idle"}, act_v, 5'b0);
            end else if (n < nbits && c == kn(n, inc)) begin
                exp_bit = gold[n % 127] ^ (INJ && err_bit >= 0 && n == err_bit + 1);
                check($sformatf("%s bit%0d", name, n), act_v,
                      {1'b1, exp_bit, 1'b1, (n % 127 == 0), exp_clk});
                n++;
            end else if (act_v !== {1'b1, exp_bit, 1'b0, 1'b0, exp_clk}) begin
                bad++;
            end
            err_inject = (c == k_err);
            enable     = (c < k_drop);
            step();
        end
        err_inject = 1'b0;
        check({name, " between-strobe cycles bad"}, bad, 0);
        check({name, " bits emitted"}, n, nbits);
    endtask

    task automatic wait_strobe(input string name, output u64_t t);
        step();
        for (int i = 0; i < 1000 && !bit_strobe; i++) step();
        check({name, " strobe seen"}, bit_strobe, 1'b1);
        t = cyc;
    endtask

    initial begin
        vec_t vecs[22];
        u64_t t[8];
        u64_t k4, r, j_prev, j_m;
        int   bad;

        for (int i = 0; i < 7; i++) gold[i] = 1'b1;
        for (int i = 7; i < 127; i++) gold[i] = gold[i-6] ^ gold[i-7];

        // Two-cycle bits (increment = half scale) make every edge case a few cycles long.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, HALF,  4'b0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, HALF,  4'b0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, HALF,  4'b1111};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, HALF,  4'b1100};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, HALF,  4'b1110};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, HALF,  4'b1100};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, HALF,  4'b1110};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, HALF,  4'b1100};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, HALF,  4'b0000};
        vecs[10] = '{1'b0, 1'b0, 1'b0, HALF,  4'b0000};
        vecs[11] = '{1'b0, 1'b1, 1'b0, HALF,  4'b1111};
        vecs[12] = '{1'b0, 1'b1, 1'b0, HALF,  4'b1100};
        vecs[13] = '{1'b0, 1'b0, 1'b0, HALF,  4'b1110};
        vecs[14] = '{1'b0, 1'b1, 1'b0, HALF,  4'b1100};
        vecs[15] = '{1'b0, 1'b1, 1'b0, HALF,  4'b1110};
        vecs[16] = '{1'b1, 1'b1, 1'b0, HALF,  4'b0000};
        vecs[17] = '{1'b0, 1'b0, 1'b0, HALF,  4'b0000};
        vecs[18] = '{1'b0, 1'b1, 1'b0, HALF,  4'b1111};
        vecs[19] = '{1'b0, 1'b1, 1'b0, HALF,  4'b1100};
        vecs[20] = '{1'b0, 1'b1, 1'b0, HALF,  4'b1100};
        vecs[21] = '{1'b1, 1'b0, 1'b0, HALF,  4'b0000};

        for (int i = 0; i < 22; i++) begin
            rst       = vecs[i].rst;
            enable    = vecs[i].en;
            rate_load = vecs[i].ld;
            rate_inc  = vecs[i].inc;
            step();
            check($sformatf("vec%0d", i), {running, m_seq_out, bit_strobe, frame_start}, vecs[i].exp);
        end
        rate_load = 1'b0;
        rst       = 1'b0;

        // Loaded rate but no enable: line stays quiet.
        rate_inc = INC_10K; rate_load = 1'b1; step();
        rate_load = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if ({running, m_seq_out, bit_strobe, frame_start, bit_clk} !== 5'b0) bad++;
            step();
        end
        check("idle 1000 cycles bad", bad, 0);

        run_seq("10k", INC_10K, 130, -1);

        // Mid-bit rate change.
        rate_inc = INC_10K; rate_load = 1'b1; step();
        rate_load = 1'b0; enable = 1'b1; step();
        check("rate first strobe", bit_strobe, 1'b1);
        t[0] = cyc;
        for (int i = 1; i < 8; i++) begin
            wait_strobe($sformatf("rate s%0d", i), t[i]);
            if (i == 3) begin
                repeat (50) step();
                rate_inc = INC_20K; rate_load = 1'b1; step();
                rate_load = 1'b0;
            end
        end
        for (int i = 1; i <= 4; i++)
            check($sformatf("rate old len%0d", i), t[i] - t[i-1], kn(i, INC_10K) - kn(i - 1, INC_10K));
        k4 = kn(4, INC_10K);
        r  = (k4 * u64_t'(INC_10K)) & 64'hFFFF_FFFF;
        j_prev = 0;
        for (int m = 1; m <= 3; m++) begin
            j_m = ((u64_t'(m) << 32) - r + u64_t'(INC_20K) - 1) / u64_t'(INC_20K);
            check($sformatf("rate new len%0d", m), t[4+m] - t[3+m], j_m - j_prev);
            j_prev = j_m;
        end
        enable = 1'b0;
        for (int i = 0; i < 300 && running; i++) step();
        check("rate stop outputs", {running, m_seq_out, bit_strobe}, 3'b000);

        // Reset in the middle of a bit aborts at once, then restart looks like a fresh sequence.
        rate_inc = INC_10K; rate_load = 1'b1; step();
        rate_load = 1'b0; enable = 1'b1; step();
        for (int i = 1; i < 4; i++) wait_strobe($sformatf("rst s%0d", i), t[i]);
        repeat (37) step();
        rst = 1'b1; step();
        check("rst mid-bit outputs", {running, m_seq_out, bit_strobe, frame_start, bit_clk}, 5'b0);
        rst = 1'b0; enable = 1'b0; step();
        run_seq("restart", INC_10K, 10, -1);

        run_seq("errinj", INC_10K, 20, 10);

        for (int k = 0; k < 3; k++) begin
            run_seq($sformatf("rand%0d", k), $urandom_range(32'd429496730, 32'd107374183), 140,
                    int'($urandom_range(100, 5)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
